// File: rtl/steer_en.sv
// Rider-detect / steering-enable FSM: decides from held load-cell samples whether a
// rider is on and standing evenly, and gates steering after a settle period.
module steer_en #(
   parameter logic        fast_sim     = 1'b0,
   parameter logic [11:0] MIN_RIDER_WT = 12'h200,
   parameter logic [11:0] WT_HYS       = 12'h040
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [11:0] lft_ld,
   input  logic [11:0] rght_ld,
   input  logic        ld_vld,
   output logic        en_steer,
   output logic        rider_off,
   output logic        tmr_full
);

   typedef enum logic [1:0] {
      IDLE     = 2'b00,
      WAIT     = 2'b01,
      STEER_EN = 2'b10
   } state_t;

   state_t      r_state;
   state_t      w_nxt_state;
   logic [11:0] r_lft;
   logic [11:0] r_rght;
   logic [25:0] r_tmr;
   logic        r_en_steer;
   logic        r_rider_off;

   logic [12:0] w_sum;
   logic [11:0] w_diff;
   logic [12:0] w_on_thr;
   logic [12:0] w_off_thr;
   logic        w_sum_gt_min;
   logic        w_sum_lt_min;
   logic        w_diff_gt_1_4;
   logic        w_diff_gt_15_16;
   logic        w_tmr_full;
   logic        w_clr_tmr;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_lft  <= '0;
         r_rght <= '0;
      end else if (ld_vld) begin
         r_lft  <= lft_ld;
         r_rght <= rght_ld;
      end
   end

   assign w_sum     = {1'b0, r_lft} + {1'b0, r_rght};
   assign w_diff    = (r_lft >= r_rght) ? (r_lft - r_rght) : (r_rght - r_lft);
   assign w_on_thr  = {1'b0, MIN_RIDER_WT} + {1'b0, WT_HYS};
   assign w_off_thr = {1'b0, MIN_RIDER_WT} - {1'b0, WT_HYS};

   // Hysteresis band: sums equal to either threshold leave the state unchanged.
   assign w_sum_gt_min    = (w_sum > w_on_thr);
   assign w_sum_lt_min    = (w_sum < w_off_thr);
   assign w_diff_gt_1_4   = ({1'b0, w_diff} > (w_sum >> 2));
   assign w_diff_gt_15_16 = ({1'b0, w_diff} > (w_sum - (w_sum >> 4)));

   assign w_tmr_full = fast_sim ? (&r_tmr[14:0]) : (&r_tmr);

   // Saturating settle timer; parks at terminal count so tmr_full stays high.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_tmr <= '0;
      else if (w_clr_tmr)
         r_tmr <= '0;
      else if (!w_tmr_full)
         r_tmr <= r_tmr + 26'd1;
   end

   always_comb begin
      w_nxt_state = r_state;
      w_clr_tmr   = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_sum_gt_min) begin
               w_nxt_state = WAIT;
               w_clr_tmr   = 1'b1;
            end
         end
         WAIT: begin
            if (w_sum_lt_min)
               w_nxt_state = IDLE;
            else if (w_diff_gt_1_4)
               w_clr_tmr = 1'b1;
            else if (w_tmr_full)
               w_nxt_state = STEER_EN;
         end
         STEER_EN: begin
            if (w_sum_lt_min)
               w_nxt_state = IDLE;
            else if (w_diff_gt_15_16) begin
               w_nxt_state = WAIT;
               w_clr_tmr   = 1'b1;
            end
         end
         default: w_nxt_state = IDLE;
      endcase
   end

   // Outputs are decoded from next state so they change on the same edge as the state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_en_steer  <= 1'b0;
         r_rider_off <= 1'b1;
      end else begin
         r_state     <= w_nxt_state;
         r_en_steer  <= (w_nxt_state == STEER_EN);
         r_rider_off <= (w_nxt_state == IDLE);
      end
   end

   assign en_steer  = r_en_steer;
   assign rider_off = r_rider_off;
   assign tmr_full  = w_tmr_full;

endmodule

// File: tb/tb_steer_en.sv
// Scoreboard bench for steer_en (fast_sim=1): expectations are queued with an
// edge offset when stimulus is driven and compared as each offset is reached.
module tb_steer_en;

   localparam int SETTLE = 32768;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        ld_vld = 1'b0;
   logic [11:0] lft_ld = '0;
   logic [11:0] rght_ld = '0;
   logic        en_steer;
   logic        rider_off;
   logic        tmr_full;

   int nvec = 0;
   int nerr = 0;

   typedef struct {
      string name;
      int    at;
      logic  en;
      logic  off;
      logic  full;
   } exp_t;

   exp_t sb[$];
   exp_t e;

   steer_en #(.fast_sim(1'b1)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .lft_ld   (lft_ld),
      .rght_ld  (rght_ld),
      .ld_vld   (ld_vld),
      .en_steer (en_steer),
      .rider_off(rider_off),
      .tmr_full (tmr_full)
   );

   always #5 clk = ~clk;

   // at = number of falling edges after the capture edge of the last load
   task automatic push_exp(input string n, input int at, input logic en, input logic off,
                           input logic full);
      exp_t x;
      x.name = n; x.at = at; x.en = en; x.off = off; x.full = full;
      sb.push_back(x);
   endtask

   // Called on a falling edge; returns on the falling edge after the capture edge.
   task automatic load(input logic [11:0] l, input logic [11:0] r);
      lft_ld = l; rght_ld = r; ld_vld = 1'b1;
      @(negedge clk);
      ld_vld = 1'b0;
   endtask

   task automatic test_reset();
      int t = 0;
      #1 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      push_exp("reset_values", 0, 1'b0, 1'b1, 1'b0);
      while (sb.size() > 0) begin
         if (sb[0].at > t) begin @(negedge clk); t++; end
         else begin
            e = sb.pop_front(); nvec++;
            if ({en_steer, rider_off, tmr_full} !== {e.en, e.off, e.full}) begin
               nerr++;
               $display("FAIL %s: en/off/full=%b%b%b expected %b%b%b", e.name,
                        en_steer, rider_off, tmr_full, e.en, e.off, e.full);
            end
         end
      end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_hys_idle();
      int t = 0;
      load(12'h120, 12'h120);   // sum 0x240 == on threshold
      push_exp("idle_on_thr_hold", 1, 1'b0, 1'b1, 1'b0);
      push_exp("idle_on_thr_hold_late", 4, 1'b0, 1'b1, 1'b0);
      while (sb.size() > 0) begin
         if (sb[0].at > t) begin @(negedge clk); t++; end
         else begin
            e = sb.pop_front(); nvec++;
            if ({en_steer, rider_off, tmr_full} !== {e.en, e.off, e.full}) begin
               nerr++;
               $display("FAIL %s: en/off/full=%b%b%b expected %b%b%b", e.name,
                        en_steer, rider_off, tmr_full, e.en, e.off, e.full);
            end
         end
      end
   endtask

   task automatic test_no_vld();
      int t = 0;
      lft_ld = 12'h800; rght_ld = 12'h800;
      push_exp("no_vld_ignored", 4, 1'b0, 1'b1, 1'b0);
      while (sb.size() > 0) begin
         if (sb[0].at > t) begin @(negedge clk); t++; end
         else begin
            e = sb.pop_front(); nvec++;
            if ({en_steer, rider_off, tmr_full} !== {e.en, e.off, e.full}) begin
               nerr++;
               $display("FAIL %s: en/off/full=%b%b%b expected %b%b%b", e.name,
                        en_steer, rider_off, tmr_full, e.en, e.off, e.full);
            end
         end
      end
      lft_ld = '0; rght_ld = '0;
   endtask

   // WAIT entered at t=1 with timer cleared; full at t=SETTLE; STEER_EN at t=SETTLE+1.
   task automatic test_settle();
      int t = 0;
      load(12'h150, 12'h150);
      push_exp("settle_capture_only", 0, 1'b0, 1'b1, 1'b0);
      push_exp("settle_enter_wait", 1, 1'b0, 1'b0, 1'b0);
      push_exp("settle_tmr_not_full", SETTLE - 1, 1'b0, 1'b0, 1'b0);
      push_exp("settle_not_before", SETTLE, 1'b0, 1'b0, 1'b1);
      push_exp("settle_en_steer", SETTLE + 1, 1'b1, 1'b0, 1'b1);
      while (sb.size() > 0) begin
         if (sb[0].at > t) begin @(negedge clk); t++; end
         else begin
            e = sb.pop_front(); nvec++;
            if ({en_steer, rider_off, tmr_full} !== {e.en, e.off, e.full}) begin
               nerr++;
               $display("FAIL %s: en/off/full=%b%b%b expected %b%b%b", e.name,
                        en_steer, rider_off, tmr_full, e.en, e.off, e.full);
            end
         end
      end
   endtask

   task automatic test_steer_diff();
      int t = 0;
      load(12'h2D0, 12'h030);   // diff 0x2A0 <= 0x2D0
      push_exp("diff_2a0_stays", 2, 1'b1, 1'b0, 1'b1);
      while (sb.size() > 0) begin
         if (sb[0].at > t) begin @(negedge clk); t++; end
         else begin
            e = sb.pop_front(); nvec++;
            if ({en_steer, rider_off, tmr_full} !== {e.en, e.off, e.full}) begin
               nerr++;
               $display("FAIL %s: en/off/full=%b%b%b expected %b%b%b", e.name,
                        en_steer, rider_off, tmr_full, e.en, e.off, e.full);
            end
         end
      end
      t = 0;
      load(12'h2F0, 12'h010);   // diff 0x2E0 > 0x2D0
      push_exp("diff_2e0_not_yet", 0, 1'b1, 1'b0, 1'b1);
      push_exp("diff_2e0_to_wait", 1, 1'b0, 1'b0, 1'b0);
      push_exp("diff_wait_holds", 3, 1'b0, 1'b0, 1'b0);
      while (sb.size() > 0) begin
         if (sb[0].at > t) begin @(negedge clk); t++; end
         else begin
            e = sb.pop_front(); nvec++;
            if ({en_steer, rider_off, tmr_full} !== {e.en, e.off, e.full}) begin
               nerr++;
               $display("FAIL %s: en/off/full=%b%b%b expected %b%b%b", e.name,
                        en_steer, rider_off, tmr_full, e.en, e.off, e.full);
            end
         end
      end
   endtask

   // Unbalanced samples keep clearing the timer, so the balanced settle must take
   // the full period from the balanced load (timer is 0 right after its capture).
   task automatic test_wait_clear();
      int t;
      for (int k = 0; k < 2; k++) begin
         t = 0;
         load(12'h200, 12'h0A0);   // diff 0x160 > 0x0A8
         push_exp($sformatf("wait_clear_%0d", k), 4000, 1'b0, 1'b0, 1'b0);
         while (sb.size() > 0) begin
            if (sb[0].at > t) begin @(negedge clk); t++; end
            else begin
               e = sb.pop_front(); nvec++;
               if ({en_steer, rider_off, tmr_full} !== {e.en, e.off, e.full}) begin
                  nerr++;
                  $display("FAIL %s: en/off/full=%b%b%b expected %b%b%b", e.name,
                           en_steer, rider_off, tmr_full, e.en, e.off, e.full);
               end
            end
         end
      end
      t = 0;
      load(12'h150, 12'h150);
      push_exp("restart_tmr_not_full", SETTLE - 2, 1'b0, 1'b0, 1'b0);
      push_exp("restart_not_before", SETTLE - 1, 1'b0, 1'b0, 1'b1);
      push_exp("restart_en_steer", SETTLE, 1'b1, 1'b0, 1'b1);
      while (sb.size() > 0) begin
         if (sb[0].at > t) begin @(negedge clk); t++; end
         else begin
            e = sb.pop_front(); nvec++;
            if ({en_steer, rider_off, tmr_full} !== {e.en, e.off, e.full}) begin
               nerr++;
               $display("FAIL %s: en/off/full=%b%b%b expected %b%b%b", e.name,
                        en_steer, rider_off, tmr_full, e.en, e.off, e.full);
            end
         end
      end
   endtask

   task automatic test_hys_steer();
      int t = 0;
      load(12'h0E0, 12'h0E0);   // sum 0x1C0 == off threshold
      push_exp("steer_off_thr_hold", 3, 1'b1, 1'b0, 1'b1);
      while (sb.size() > 0) begin
         if (sb[0].at > t) begin @(negedge clk); t++; end
         else begin
            e = sb.pop_front(); nvec++;
            if ({en_steer, rider_off, tmr_full} !== {e.en, e.off, e.full}) begin
               nerr++;
               $display("FAIL %s: en/off/full=%b%b%b expected %b%b%b", e.name,
                        en_steer, rider_off, tmr_full, e.en, e.off, e.full);
            end
         end
      end
   endtask

   task automatic test_async_reset();
      int t = 0;
      #2 rst_n = 1'b0;
      #1;
      push_exp("async_reset_mid_steer", 0, 1'b0, 1'b1, 1'b0);
      while (sb.size() > 0) begin
         if (sb[0].at > t) begin @(negedge clk); t++; end
         else begin
            e = sb.pop_front(); nvec++;
            if ({en_steer, rider_off, tmr_full} !== {e.en, e.off, e.full}) begin
               nerr++;
               $display("FAIL %s: en/off/full=%b%b%b expected %b%b%b", e.name,
                        en_steer, rider_off, tmr_full, e.en, e.off, e.full);
            end
         end
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_hys_drop();
      int t = 0;
      load(12'h150, 12'h150);
      push_exp("drop_enter_wait", 1, 1'b0, 1'b0, 1'b0);
      while (sb.size() > 0) begin
         if (sb[0].at > t) begin @(negedge clk); t++; end
         else begin
            e = sb.pop_front(); nvec++;
            if ({en_steer, rider_off, tmr_full} !== {e.en, e.off, e.full}) begin
               nerr++;
               $display("FAIL %s: en/off/full=%b%b%b expected %b%b%b", e.name,
                        en_steer, rider_off, tmr_full, e.en, e.off, e.full);
            end
         end
      end
      t = 0;
      load(12'h0E0, 12'h0DF);   // sum 0x1BF < off threshold
      push_exp("drop_not_yet", 0, 1'b0, 1'b0, 1'b0);
      push_exp("drop_rider_off", 1, 1'b0, 1'b1, 1'b0);
      while (sb.size() > 0) begin
         if (sb[0].at > t) begin @(negedge clk); t++; end
         else begin
            e = sb.pop_front(); nvec++;
            if ({en_steer, rider_off, tmr_full} !== {e.en, e.off, e.full}) begin
               nerr++;
               $display("FAIL %s: en/off/full=%b%b%b expected %b%b%b", e.name,
                        en_steer, rider_off, tmr_full, e.en, e.off, e.full);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_hys_idle();
      test_no_vld();
      test_settle();
      test_steer_diff();
      test_wait_clear();
      test_hys_steer();
      test_async_reset();
      test_hys_drop();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
